// File: rtl/riscv_ifq_pkg.sv
// Shared types for the instruction fetch queue.
// No logic; state encoding and the parcel used for entries that carry no fetched data.
// Not applicable (type definitions only).
package riscv_ifq_pkg;

    typedef enum logic [1:0] {
        IFQ_IDLE  = 2'd0,
        IFQ_REQ   = 2'd1,
        IFQ_DRAIN = 2'd2
    } ifq_state_t;

    localparam logic [31:0] IFQ_NOP_PARCEL = '0;

endpackage

// File: rtl/riscv_ifq_fifo.sv
// Parcel FIFO with two ordered write ports (port a is older than port b), one read port, clear.
// Writes land on the clock edge; head read is combinational from the read pointer.
// No internal backpressure: the caller guarantees count never exceeds DEPTH.
module riscv_ifq_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clr,
    input  logic             i_push_a,
    input  logic [WIDTH-1:0] i_push_a_dat,
    input  logic             i_push_b,
    input  logic [WIDTH-1:0] i_push_b_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic [AW:0]      o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;
    logic [AW-1:0]    w_wptr_b;

    // Port b follows port a when both write in the same cycle.
    assign w_wptr_b = r_wptr + AW'(i_push_a);

    always_ff @(posedge clk) begin
        if (i_push_a) r_mem[r_wptr]   <= i_push_a_dat;
        if (i_push_b) r_mem[w_wptr_b] <= i_push_b_dat;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            r_wptr <= r_wptr + AW'(i_push_a) + AW'(i_push_b);
            r_rptr <= r_rptr + AW'(i_pop);
            r_cnt  <= r_cnt + (AW+1)'(i_push_a) + (AW+1)'(i_push_b) - (AW+1)'(i_pop);
        end
    end

    assign o_head_dat = r_mem[r_rptr];
    assign o_count    = r_cnt;
    assign o_empty    = (r_cnt == '0);

endmodule

// File: rtl/riscv_if_queue.sv
// Instruction fetch queue: issues single-word imem requests, buffers {pc, parcel, flags}; RV12_IFQ_BYPASS_EN adds empty-queue bypass.
// Parcel valid one cycle after imem_ack (same cycle when the bypass is enabled and the queue is empty).
// if_stall_nxt_pc when flushing, draining, waiting for ack, or no free slot after this cycle's pop.
module riscv_if_queue
    import riscv_ifq_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              PARCEL_SIZE = 32,
    parameter int              DEPTH       = 4,
    parameter logic [XLEN-1:0] PC_INIT     = 'h200
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [XLEN-1:0]            if_nxt_pc,
    output logic                       if_stall_nxt_pc,
    input  logic                       if_stall,
    input  logic                       if_flush,
    output logic [PARCEL_SIZE-1:0]     if_parcel,
    output logic [XLEN-1:0]            if_parcel_pc,
    output logic [PARCEL_SIZE/16-1:0]  if_parcel_valid,
    output logic                       if_parcel_misaligned,
    output logic                       if_parcel_page_fault,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_adr,
    input  logic [PARCEL_SIZE-1:0]     imem_q,
    input  logic                       imem_ack,
    input  logic                       imem_err
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [PARCEL_SIZE-1:0] parcel;
        logic                   misaligned;
        logic                   fault;
    } ifq_entry_t;

    localparam int EW = $bits(ifq_entry_t);

    ifq_state_t      r_state;
    logic            r_req;
    logic [XLEN-1:0] r_adr;

    ifq_entry_t  w_head, w_rsp, w_mis, w_out;
    logic [AW:0]   w_cnt;
    logic [AW+1:0] w_occ;
    logic w_empty, w_ack_live, w_byp, w_out_vld, w_pop_any, w_pop_fifo;
    logic w_stall, w_accept, w_aligned, w_push_a, w_push_b;

    assign w_ack_live = (r_state == IFQ_REQ) & imem_ack;
    assign w_aligned  = (if_nxt_pc[1:0] == 2'b00);
    assign w_rsp      = '{pc: r_adr, parcel: imem_q, misaligned: 1'b0, fault: imem_err};
    assign w_mis      = '{pc: if_nxt_pc, parcel: PARCEL_SIZE'(IFQ_NOP_PARCEL), misaligned: 1'b1, fault: 1'b0};

`ifdef RV12_IFQ_BYPASS_EN
    assign w_byp = w_empty & w_ack_live & !if_flush;
`else
    assign w_byp = 1'b0;
`endif

    assign w_out      = w_byp ? w_rsp : w_head;
    assign w_out_vld  = w_byp | !w_empty;
    assign w_pop_any  = !if_stall & w_out_vld;
    assign w_pop_fifo = !if_stall & !w_empty & !if_flush;

    // The outstanding request already owns a slot, so it counts towards occupancy.
    assign w_occ   = {1'b0, w_cnt} + (AW+2)'(r_state == IFQ_REQ);
    assign w_stall = if_flush | (r_state == IFQ_DRAIN) | ((r_state == IFQ_REQ) & !imem_ack) |
                     ((w_occ - (AW+2)'(w_pop_any)) >= (AW+2)'(DEPTH));
    assign w_accept = !w_stall;

    assign w_push_a = w_ack_live & !if_flush & !(w_byp & !if_stall);
    assign w_push_b = w_accept & !w_aligned;

    riscv_ifq_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rstn         (rstn),
        .i_clr        (if_flush),
        .i_push_a     (w_push_a),
        .i_push_a_dat (w_rsp),
        .i_push_b     (w_push_b),
        .i_push_b_dat (w_mis),
        .i_pop        (w_pop_fifo),
        .o_head_dat   (w_head),
        .o_count      (w_cnt),
        .o_empty      (w_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IFQ_IDLE;
            r_req   <= 1'b0;
            r_adr   <= PC_INIT;
        end else if (if_flush) begin
            if (r_state == IFQ_REQ && !imem_ack) begin
                r_state <= IFQ_DRAIN;
            end else if (imem_ack) begin
                r_state <= IFQ_IDLE;
                r_req   <= 1'b0;
            end
        end else begin
            if (r_state != IFQ_IDLE && imem_ack) begin
                r_state <= IFQ_IDLE;
                r_req   <= 1'b0;
            end
            // Accept only happens from IDLE or on the ack cycle, so it overrides the drop above.
            if (w_accept && w_aligned) begin
                r_state <= IFQ_REQ;
                r_req   <= 1'b1;
                r_adr   <= if_nxt_pc;
            end
        end
    end

    assign if_stall_nxt_pc      = w_stall;
    assign imem_req             = r_req;
    assign imem_adr             = r_adr;
    assign if_parcel_valid      = {(PARCEL_SIZE/16){w_out_vld}};
    assign if_parcel            = w_out_vld ? w_out.parcel : '0;
    assign if_parcel_pc         = w_out_vld ? w_out.pc : '0;
    assign if_parcel_misaligned = w_out_vld & w_out.misaligned;
    assign if_parcel_page_fault = w_out_vld & w_out.fault;

endmodule
